frame_tx_scheduler: RTL and testbench

- Transmit-side frame controller for the serial Hamming link.
- Builds fixed 64-bit frames: an 8-bit head 01111110, then 8 Hamming(7,4) codeword slots.
- Pulls codewords from the encoder through a valid/ready handshake and sequences them MSB-first onto a 1-bit line.
- Inserts an all-zero idle codeword when the encoder has nothing ready; frame period and head format match the receive-side frame synchronizer.

---
 rtl/frame_tx_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_frame_tx_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// ---------------------------------------------------------------------------
// frame_tx_scheduler
// Transmit-side frame controller for the serial Hamming link. Every frame is
// FRAME_LEN bits long. It starts with the HEAD_LEN-bit head pattern. The head
// is followed by (FRAME_LEN-HEAD_LEN)/CW_LEN codeword slots.
//
// Codewords are pulled from the encoder with a valid/ready handshake. Each
// codeword is serialised MSB first onto data_out. When the encoder has
// nothing to offer at a slot start, an all-zero codeword is sent in its
// place. The all-zero word is itself a legal Hamming(7,4) codeword.
//
// The frame period and head format match the receive-side frame
// synchronizer. Because no bit stuffing is performed, the payload may
// reproduce the head pattern.
// ---------------------------------------------------------------------------
module frame_tx_scheduler #(
    parameter int                    FRAME_LEN    = 64,
    parameter int                    HEAD_LEN     = 8,
    parameter logic [HEAD_LEN-1:0]   HEAD_PATTERN = 8'b01111110,
    parameter int                    CW_LEN       = 7
) (
    input  logic              clk_out,
    input  logic              rst,
    input  logic              enable,
    input  logic [CW_LEN-1:0] cw_in,
    input  logic              cw_valid,
    output logic              cw_ready,
    output logic              data_out,
    output logic              frame_start,
    output logic [1:0]        tx_state,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       idle_cw_cnt
);

    localparam int POS_W   = $clog2(FRAME_LEN);
    localparam int SLOT_W  = $clog2(CW_LEN);
    localparam int HIDX_W  = $clog2(HEAD_LEN);
    localparam int SHIFT_W = CW_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HEAD    = 2'b01,
        ST_PAYLOAD = 2'b10
    } tx_state_e;

    // Head bit selected by the frame position (head is sent MSB first).
    function automatic logic head_bit(input logic [POS_W-1:0] p);
        logic [HIDX_W-1:0] idx;
        idx = HIDX_W'(HEAD_LEN - 1) - p[HIDX_W-1:0];
        return HEAD_PATTERN[idx];
    endfunction

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    tx_state_e          state_r;
    tx_state_e          state_nxt_s;
    logic [POS_W-1:0]   pos_r;
    logic [POS_W-1:0]   pos_nxt_s;
    logic [SLOT_W-1:0]  slot_bit_r;
    logic [SLOT_W-1:0]  slot_bit_nxt_s;
    logic [SHIFT_W-1:0] shift_r;
    logic [SHIFT_W-1:0] shift_nxt_s;
    logic               data_out_r;
    logic               data_nxt_s;
    logic               frame_start_r;
    logic               frame_start_nxt_s;
    logic [15:0]        frame_cnt_r;
    logic [15:0]        idle_cw_cnt_r;

    // Decoded conditions
    logic               head_last_s;
    logic               frame_last_s;
    logic               slot_start_s;
    logic               frame_done_s;
    logic               idle_ins_s;

    // Decode the frame position into head-end, frame-end and slot-start.
    always_comb begin
        head_last_s  = (pos_r == POS_W'(HEAD_LEN - 1));
        frame_last_s = (pos_r == POS_W'(FRAME_LEN - 1));
        slot_start_s = (state_r == ST_PAYLOAD) && (slot_bit_r == SLOT_W'(0));
    end

    // FSM state register; the reset aborts any frame in progress.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state. Enable is only looked at in IDLE and on the last bit
    // of a frame, so a started frame always runs to completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_HEAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (head_last_s) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HEAD;
                end
            end
            ST_PAYLOAD: begin
                if (frame_last_s) begin
                    if (enable) begin
                        state_nxt_s = ST_HEAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: position, slot phase, shifter, serial bit and
    // frame_start, plus the counter increment strobes.
    always_comb begin
        pos_nxt_s         = pos_r;
        slot_bit_nxt_s    = slot_bit_r;
        shift_nxt_s       = shift_r;
        data_nxt_s        = data_out_r;
        frame_start_nxt_s = 1'b0;
        frame_done_s      = 1'b0;
        idle_ins_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Line held low; the entry edge into HEAD drives no bit.
                pos_nxt_s      = POS_W'(0);
                slot_bit_nxt_s = SLOT_W'(0);
                shift_nxt_s    = SHIFT_W'(0);
                data_nxt_s     = 1'b0;
            end
            ST_HEAD: begin
                data_nxt_s        = head_bit(pos_r);
                frame_start_nxt_s = (pos_r == POS_W'(0));
                pos_nxt_s         = pos_r + POS_W'(1);
                slot_bit_nxt_s    = SLOT_W'(0);
            end
            ST_PAYLOAD: begin
                if (slot_start_s) begin
                    if (cw_valid) begin
                        data_nxt_s  = cw_in[CW_LEN-1];
                        shift_nxt_s = cw_in[CW_LEN-2:0];
                    end else begin
                        // Underflow: send the all-zero codeword instead.
                        data_nxt_s  = 1'b0;
                        shift_nxt_s = SHIFT_W'(0);
                        idle_ins_s  = 1'b1;
                    end
                end else begin
                    data_nxt_s  = shift_r[SHIFT_W-1];
                    shift_nxt_s = {shift_r[SHIFT_W-2:0], 1'b0};
                end
                if (slot_bit_r == SLOT_W'(CW_LEN - 1)) begin
                    slot_bit_nxt_s = SLOT_W'(0);
                end else begin
                    slot_bit_nxt_s = slot_bit_r + SLOT_W'(1);
                end
                if (frame_last_s) begin
                    pos_nxt_s    = POS_W'(0);
                    frame_done_s = 1'b1;
                end else begin
                    pos_nxt_s    = pos_r + POS_W'(1);
                end
            end
            default: begin
                pos_nxt_s      = POS_W'(0);
                slot_bit_nxt_s = SLOT_W'(0);
                shift_nxt_s    = SHIFT_W'(0);
                data_nxt_s     = 1'b0;
            end
        endcase
    end

    // Position, slot phase and codeword shift register.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            pos_r      <= POS_W'(0);
            slot_bit_r <= SLOT_W'(0);
            shift_r    <= SHIFT_W'(0);
        end else begin
            pos_r      <= pos_nxt_s;
            slot_bit_r <= slot_bit_nxt_s;
            shift_r    <= shift_nxt_s;
        end
    end

    // Registered serial line and frame-start marker.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            data_out_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            data_out_r    <= data_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_done_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Idle-codeword insertion counter; wraps naturally at 16 bits.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            idle_cw_cnt_r <= 16'd0;
        end else if (idle_ins_s) begin
            idle_cw_cnt_r <= idle_cw_cnt_r + 16'd1;
        end else begin
            idle_cw_cnt_r <= idle_cw_cnt_r;
        end
    end

    // ready is combinational so the encoder can hand over a word on the
    // same edge that starts the slot.
    assign cw_ready    = slot_start_s;
    assign data_out    = data_out_r;
    assign frame_start = frame_start_r;
    assign tx_state    = state_r;
    assign frame_cnt   = frame_cnt_r;
    assign idle_cw_cnt = idle_cw_cnt_r;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for frame_tx_scheduler.
// Each frame is described as eight slots, each either a codeword or an
// underflow. The expected 64-bit line image is assembled by concatenating
// the head with the slot contents. Counters are predicted from frame and
// idle-slot totals.
// ---------------------------------------------------------------------------
module tb_frame_tx_scheduler;

    localparam int FL = 64;
    localparam int HL = 8;
    localparam int CL = 7;
    localparam int NS = (FL - HL) / CL;

    logic        clk_out = 1'b0;
    logic        rst;
    logic        enable;
    logic [CL-1:0] cw_in;
    logic        cw_valid;
    logic        cw_ready;
    logic        data_out;
    logic        frame_start;
    logic [1:0]  tx_state;
    logic [15:0] frame_cnt;
    logic [15:0] idle_cw_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;
    int exp_idle   = 0;

    logic [CL-1:0] slot_cw  [NS];
    bit            slot_vld [NS];

    frame_tx_scheduler dut (
        .clk_out     (clk_out),
        .rst         (rst),
        .enable      (enable),
        .cw_in       (cw_in),
        .cw_valid    (cw_valid),
        .cw_ready    (cw_ready),
        .data_out    (data_out),
        .frame_start (frame_start),
        .tx_state    (tx_state),
        .frame_cnt   (frame_cnt),
        .idle_cw_cnt (idle_cw_cnt)
    );

    always #5 clk_out = ~clk_out;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},    16'(data_out),    16'd0);
        check({tag, "_frame_start"}, 16'(frame_start), 16'd0);
        check({tag, "_cw_ready"},    16'(cw_ready),    16'd0);
        check({tag, "_tx_state"},    16'(tx_state),    16'd0);
        check({tag, "_frame_cnt"},   frame_cnt,        16'd0);
        check({tag, "_idle_cnt"},    idle_cw_cnt,      16'd0);
    endtask

    // Raise enable in IDLE: one edge into HEAD with no bit driven yet.
    task automatic start_from_idle();
        enable = 1'b1;
        check("idle_ready", 16'(cw_ready), 16'd0);
        check("idle_state", 16'(tx_state), 16'd0);
        @(posedge clk_out); #1;
        check("lat_state",   16'(tx_state), 16'd1);
        check("lat_no_bit",  16'(data_out), 16'd0);
    endtask

    // Run one frame whose first edge is the next one. drop_k deasserts enable
    // before edge drop_k; abort_k asserts reset when pos reaches abort_k.
    task automatic run_frame(input int drop_k, input int abort_k);
        logic [FL-1:0] fr;
        int nidle;
        bit sl;
        int s;
        fr = '0;
        fr[FL-1 -: HL] = 8'b01111110;
        nidle = 0;
        for (int i = 0; i < NS; i++) begin
            if (slot_vld[i]) fr[FL-1-HL-CL*i -: CL] = slot_cw[i];
            else nidle++;
        end
        for (int k = 0; k < FL; k++) begin
            sl = (k >= HL) && (((k - HL) % CL) == 0);
            if (k == drop_k) enable = 1'b0;
            if (sl) begin
                s = (k - HL) / CL;
                cw_valid = slot_vld[s];
                cw_in = slot_vld[s] ? slot_cw[s] : CL'($urandom);
            end else begin
                cw_valid = 1'($urandom);
                cw_in = CL'($urandom);
            end
            if (k == abort_k) begin
                #2 rst = 1'b1;
                #1 check_all_zero("async_rst");
                exp_frames = 0;
                exp_idle = 0;
                return;
            end
            check("cw_ready", 16'(cw_ready), 16'(sl));
            check("tx_state", 16'(tx_state), (k < HL) ? 16'd1 : 16'd2);
            @(posedge clk_out); #1;
            check("data_out",    16'(data_out),    16'(fr[FL-1-k]));
            check("frame_start", 16'(frame_start), 16'(k == 0));
        end
        exp_frames++;
        exp_idle += nidle;
        check("frame_cnt",   frame_cnt,   16'(exp_frames));
        check("idle_cw_cnt", idle_cw_cnt, 16'(exp_idle));
        check("end_state",   16'(tx_state), enable ? 16'd1 : 16'd0);
    endtask

    initial begin
        int p;
        rst = 1'b1;
        enable = 1'b0;
        cw_valid = 1'b0;
        cw_in = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk_out); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk_out);
        #1;
        check_all_zero("idle_hold");

        // Continuous frames with codewords 0..7.
        start_from_idle();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NS; i++) begin
                slot_cw[i] = CL'(i);
                slot_vld[i] = 1'b1;
            end
            run_frame(-1, -1);
        end

        // Underflow at the third slot; pending words shift to later slots.
        p = 0;
        for (int i = 0; i < NS; i++) begin
            slot_vld[i] = (i != 2);
            if (i != 2) begin
                slot_cw[i] = CL'(7'h50 + p);
                p++;
            end else begin
                slot_cw[i] = '0;
            end
        end
        run_frame(-1, -1);

        // Random payloads with random underflows.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NS; i++) begin
                slot_vld[i] = ($urandom_range(0, 3) != 0);
                slot_cw[i] = CL'($urandom);
            end
            run_frame(-1, -1);
        end

        // Loopback-style payload: 7'h3F in every slot.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NS; i++) begin
                slot_vld[i] = 1'b1;
                slot_cw[i] = 7'h3F;
            end
            run_frame(-1, -1);
        end

        // Enable dropped at pos 30: the frame completes, then the line idles.
        for (int i = 0; i < NS; i++) begin
            slot_vld[i] = 1'b1;
            slot_cw[i] = CL'($urandom);
        end
        run_frame(30, -1);
        @(posedge clk_out); #1;
        check("drop_idle_data",  16'(data_out), 16'd0);
        check("drop_idle_state", 16'(tx_state), 16'd0);
        check("drop_frame_cnt",  frame_cnt,     16'(exp_frames));
        start_from_idle();
        run_frame(-1, -1);

        // Reset asserted at pos 40, then a clean frame afterwards.
        run_frame(-1, 40);
        @(posedge clk_out); #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
        enable = 1'b0;
        @(posedge clk_out); #1;
        start_from_idle();
        for (int i = 0; i < NS; i++) begin
            slot_vld[i] = ($urandom_range(0, 1) != 0);
            slot_cw[i] = CL'($urandom);
        end
        run_frame(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
